// File: rtl/tpa_pkg.sv
// Shared types and constants for the two-wire / register-interface block.
package tpa_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RIM_WR,
    RIM_RD,
    RIM_DONE,
    TW_OP,
    TW_ADDR,
    TW_WDATA,
    TW_TURN,
    TW_RSTART,
    TW_RDATA,
    TW_RSTOP
  } tpa_state_e;

  localparam logic TW_OP_WR = 1'b1;
  localparam logic TW_OP_RD = 1'b0;

  // Lengths (in bit slots) of the fixed-size frame fields
  localparam int TW_OP_LEN     = 1;
  localparam int TW_TURN_LEN   = 1;
  localparam int TW_RSTART_LEN = 1;
  localparam int TW_RSTOP_LEN  = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tpa_param_if.sv
// Register-interface handshake plus the frame-busy flag.
interface tpa_param_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          cfg_req;
  logic          cfg_cmd;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic          cfg_rdy;
  logic [DW-1:0] cfg_rdata;
  logic          tw_busy;

  modport master (
    output cfg_req, cfg_cmd, cfg_addr, cfg_wdata,
    input  cfg_rdy, cfg_rdata, tw_busy
  );

  modport slave (
    input  cfg_req, cfg_cmd, cfg_addr, cfg_wdata,
    output cfg_rdy, cfg_rdata, tw_busy
  );
endinterface

// File: rtl/tpa_regfile.sv
// Register storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module tpa_regfile #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [2**AW];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/tpa_param.sv
// Register file reachable from a parallel request/ready port and from a
// bit-serial two-wire frame on SDA (optionally qualified by SCL edges).
module tpa_param
  import tpa_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int SCL_QUAL = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCL,
  inout  wire         SDA,
  tpa_param_if.slave  cfg
);
  localparam int MAXW = max2(AW, DW);
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  tpa_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wsr_q, wsr_d;
  logic [DW-1:0] rsr_q, rsr_d;
  logic          commit_q, commit_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [2:0]    scl_q;
  logic          slot, sda_bit, start;
  logic          we;
  logic [AW-1:0] waddr, raddr, addr_shift;
  logic [DW-1:0] wdata, rword;
  logic          sda_oe, sda_o;

  function automatic logic is_last(input logic [CW-1:0] c, input int len);
    return c == CW'(len - 1);
  endfunction

  // [0],[1] synchronise SCL; [2] holds the previous synced level for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) scl_q <= '0;
    else       scl_q <= {scl_q[1:0], SCL};
  end

  assign slot       = (SCL_QUAL != 0) ? (scl_q[1] & ~scl_q[2]) : 1'b1;
  assign sda_bit    = SDA;
  assign start      = slot && !sda_bit;
  assign addr_shift = {sda_bit, addr_q[AW-1:1]};

  // A finished frame write lands the cycle after its last bit; RIM writes
  // land in RIM_WR. The two can never coincide.
  assign we    = commit_q || (state_q == RIM_WR);
  assign waddr = commit_q ? addr_q : cfg.cfg_addr;
  assign wdata = commit_q ? wsr_q : cfg.cfg_wdata;
  // During the last address slot, look up the address being completed
  assign raddr = (state_q == TW_ADDR) ? addr_shift : cfg.cfg_addr;

  tpa_regfile #(.AW(AW), .DW(DW)) u_rf (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rword)
  );

  // Next-state: arbitration in IDLE, slot-driven frame sequencing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wsr_d    = wsr_q;
    rsr_d    = rsr_q;
    commit_d = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TW_OP;
        end else if (cfg.cfg_req && !commit_q) begin
          // Hold off one cycle while a frame write commits so a read sees it
          state_d = cfg.cfg_cmd ? RIM_WR : RIM_RD;
          if (!cfg.cfg_cmd) rdata_d = rword;
        end
      end
      RIM_WR, RIM_RD: state_d = RIM_DONE;
      RIM_DONE:       state_d = IDLE;
      TW_OP: if (slot) begin
        op_d  = sda_bit;
        cnt_d = cnt_q + CW'(1);
        if (is_last(cnt_q, TW_OP_LEN)) state_d = TW_ADDR;
      end
      TW_ADDR: if (slot) begin
        addr_d = addr_shift;
        cnt_d  = cnt_q + CW'(1);
        if (is_last(cnt_q, AW)) begin
          state_d = (op_q == TW_OP_WR) ? TW_WDATA : TW_TURN;
          rsr_d   = rword;
        end
      end
      TW_WDATA: if (slot) begin
        wsr_d = {sda_bit, wsr_q[DW-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (is_last(cnt_q, DW)) begin
          state_d  = IDLE;
          commit_d = 1'b1;
        end
      end
      TW_TURN: if (slot) begin
        cnt_d = cnt_q + CW'(1);
        if (is_last(cnt_q, TW_TURN_LEN)) state_d = TW_RSTART;
      end
      TW_RSTART: if (slot) begin
        cnt_d = cnt_q + CW'(1);
        if (is_last(cnt_q, TW_RSTART_LEN)) state_d = TW_RDATA;
      end
      TW_RDATA: if (slot) begin
        rsr_d = rsr_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (is_last(cnt_q, DW)) state_d = TW_RSTOP;
      end
      TW_RSTOP: if (slot) begin
        cnt_d = cnt_q + CW'(1);
        if (is_last(cnt_q, TW_RSTOP_LEN)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Every state starts its field count from zero
    if (state_d != state_q) cnt_d = '0;
  end

  // State and datapath registers; reset aborts any frame and its pending commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      addr_q   <= '0;
      wsr_q    <= '0;
      rsr_q    <= '0;
      commit_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wsr_q    <= wsr_d;
      rsr_q    <= rsr_d;
      commit_q <= commit_d;
      rdata_q  <= rdata_d;
    end
  end

  // SDA is only driven while returning read data
  always_comb begin
    sda_oe = 1'b0;
    sda_o  = 1'b0;
    case (state_q)
      TW_RSTART: begin sda_oe = 1'b1; sda_o = 1'b0;     end
      TW_RDATA:  begin sda_oe = 1'b1; sda_o = rsr_q[0]; end
      TW_RSTOP:  begin sda_oe = 1'b1; sda_o = 1'b1;     end
      default: ;
    endcase
  end

  assign SDA           = sda_oe ? sda_o : 1'bz;
  assign cfg.cfg_rdy   = (state_q == RIM_WR) || (state_q == RIM_RD);
  assign cfg.cfg_rdata = rdata_q;
  assign cfg.tw_busy   = state_q inside {TW_OP, TW_ADDR, TW_WDATA, TW_TURN,
                                         TW_RSTART, TW_RDATA, TW_RSTOP};
endmodule

// File: tb/tb_tpa_param.sv
// Bench for tpa_param: directed frames plus random RIM/frame traffic against
// an array model. dut0 samples SDA every clk; dut1 is SCL-qualified.
module tb_tpa_param;
  import tpa_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl1;
  logic sda0_en, sda0_v, sda1_en, sda1_v;
  wire  sda0, sda1;

  assign sda0 = sda0_en ? sda0_v : 1'bz;
  assign sda1 = sda1_en ? sda1_v : 1'bz;
  pullup pu0 (sda0);
  pullup pu1 (sda1);

  tpa_param_if #(.AW(8), .DW(16)) if0 ();
  tpa_param_if #(.AW(4), .DW(8))  if1 ();

  tpa_param #(.AW(8), .DW(16), .SCL_QUAL(0)) u_dut0 (
    .clk(clk), .reset(reset), .SCL(1'b0), .SDA(sda0), .cfg(if0.slave));
  tpa_param #(.AW(4), .DW(8), .SCL_QUAL(1)) u_dut1 (
    .clk(clk), .reset(reset), .SCL(scl1), .SDA(sda1), .cfg(if1.slave));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] mdl [256];
  bit          vld [256];
  logic [7:0]  wq [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge
  task automatic rim_xfer(input bit which, input bit wr, input logic [7:0] a,
                          input logic [15:0] d, output logic [15:0] rd, output int lat);
    if (which) begin
      if1.cfg_req = 1'b1; if1.cfg_cmd = wr; if1.cfg_addr = a[3:0]; if1.cfg_wdata = d[7:0];
    end else begin
      if0.cfg_req = 1'b1; if0.cfg_cmd = wr; if0.cfg_addr = a; if0.cfg_wdata = d;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(which ? if1.cfg_rdy : if0.cfg_rdy) && lat < 64);
    chk("rim_rdy", which ? if1.cfg_rdy : if0.cfg_rdy, 1'b1);
    rd = which ? {8'h00, if1.cfg_rdata} : if0.cfg_rdata;
    if1.cfg_req = 1'b0;
    if0.cfg_req = 1'b0;
    @(negedge clk);
    chk("rim_rdy_pulse", which ? if1.cfg_rdy : if0.cfg_rdy, 1'b0);
    @(negedge clk);
  endtask

  task automatic note_wr(input logic [7:0] a, input logic [15:0] d);
    mdl[a] = d;
    if (!vld[a]) begin vld[a] = 1'b1; wq.push_back(a); end
  endtask

  task automatic rim_wr(input logic [7:0] a, input logic [15:0] d);
    logic [15:0] rd; int lat;
    rim_xfer(1'b0, 1'b1, a, d, rd, lat);
    chk("rim_wr_lat", lat, 1);
    note_wr(a, d);
  endtask

  task automatic rim_rd(input logic [7:0] a);
    logic [15:0] rd; int lat;
    rim_xfer(1'b0, 1'b0, a, 16'h0, rd, lat);
    chk("rim_rd_lat", lat, 1);
    chk($sformatf("rim_rd_data[%0h]", a), rd, mdl[a]);
  endtask

  task automatic tw_write(input logic [7:0] a, input logic [15:0] d);
    logic [25:0] bits;
    bit busy_bad, rdy_bad;
    bits = {d, a, TW_OP_WR, 1'b0};
    busy_bad = 0; rdy_bad = 0;
    for (int i = 0; i < 26; i++) begin
      sda0_en = 1'b1; sda0_v = bits[i];
      @(negedge clk);
      if (if0.tw_busy !== (i < 25)) busy_bad = 1;
      if (if0.cfg_rdy) rdy_bad = 1;
    end
    sda0_en = 1'b0;
    @(negedge clk);
    chk("tw_wr_busy", busy_bad, 0);
    chk("tw_wr_rdy_quiet", rdy_bad, 0);
    note_wr(a, d);
  endtask

  task automatic tw_read(input logic [7:0] a);
    logic [9:0] bits;
    logic [19:0] obs, exp;
    bit busy_bad;
    bits = {a, TW_OP_RD, 1'b0};
    busy_bad = 0;
    for (int i = 0; i < 10; i++) begin
      sda0_en = 1'b1; sda0_v = bits[i];
      @(negedge clk);
      if (!if0.tw_busy) busy_bad = 1;
    end
    sda0_en = 1'b0;
    #1;
    for (int k = 0; k < 20; k++) begin
      obs[k] = sda0;
      if (k < 19) begin
        if (!if0.tw_busy) busy_bad = 1;
        @(negedge clk);
        #1;
      end
    end
    // released turn, start 0, data LSB-first, stop 1, released idle
    exp = {2'b11, mdl[a], 2'b01};
    chk($sformatf("tw_rd_frame[%0h]", a), obs, exp);
    chk("tw_rd_busy", busy_bad, 0);
    chk("tw_rd_busy_end", if0.tw_busy, 0);
  endtask

  // One SCL-qualified bit: glitches early, stable around the SCL rise
  task automatic tw1_bit(input logic b);
    for (int k = 0; k < 8; k++) begin
      scl1 = (k >= 4);
      sda1_en = 1'b1;
      sda1_v = (k == 0) ? 1'b0 : (k == 1) ? 1'b1 : b;
      @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    logic [7:0]  a;
    logic [15:0] d, rd;
    logic [25:0] bits;
    logic [13:0] fbits;
    int lat;

    if0.cfg_req = 0; if0.cfg_cmd = 0; if0.cfg_addr = '0; if0.cfg_wdata = '0;
    if1.cfg_req = 0; if1.cfg_cmd = 0; if1.cfg_addr = '0; if1.cfg_wdata = '0;
    sda0_en = 0; sda0_v = 1; sda1_en = 0; sda1_v = 1; scl1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", if0.tw_busy, 0);
    chk("rst_rdy", if0.cfg_rdy, 0);
    chk("rst_rdata", if0.cfg_rdata, 0);
    chk("rst_sda", sda0, 1);
    reset = 1'b0;
    @(negedge clk);

    // RIM write then read
    rim_wr(8'h12, 16'hBEEF);
    rim_rd(8'h12);

    // Frame write then RIM read
    tw_write(8'h34, 16'hA5C3);
    rim_rd(8'h34);

    // Frame read of a RIM-preloaded word
    rim_wr(8'h07, 16'h5A5A);
    tw_read(8'h07);

    // Collision: start bit and RIM write request in the same cycle
    if0.cfg_req = 1'b1; if0.cfg_cmd = 1'b1; if0.cfg_addr = 8'h01; if0.cfg_wdata = 16'h7777;
    tw_write(8'h01, 16'h2222);
    lat = 0;
    while (!if0.cfg_rdy && lat < 64) begin @(negedge clk); lat++; end
    chk("col_rdy", if0.cfg_rdy, 1);
    chk("col_busy_at_rdy", if0.tw_busy, 0);
    if0.cfg_req = 1'b0;
    repeat (2) @(negedge clk);
    note_wr(8'h01, 16'h7777);
    rim_rd(8'h01);

    // Random mix of all four transaction kinds
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      a  = 8'($urandom);
      d  = 16'($urandom);
      if (op == 1 || op == 3) a = wq[$urandom_range(0, wq.size() - 1)];
      case (op)
        0: rim_wr(a, d);
        1: rim_rd(a);
        2: tw_write(a, d);
        default: tw_read(a);
      endcase
    end

    // Reset in the middle of a frame write, after 5 data bits
    rim_wr(8'h20, 16'h1111);
    rim_rd(8'h12);
    bits = {16'hABCD, 8'h20, TW_OP_WR, 1'b0};
    for (int i = 0; i < 15; i++) begin
      sda0_en = 1'b1; sda0_v = bits[i];
      @(negedge clk);
    end
    chk("mid_busy", if0.tw_busy, 1);
    #2;
    reset = 1'b1;
    sda0_en = 1'b0;
    #1;
    chk("mid_rst_busy", if0.tw_busy, 0);
    chk("mid_rst_sda", sda0, 1);
    chk("mid_rst_rdy", if0.cfg_rdy, 0);
    chk("mid_rst_rdata", if0.cfg_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rim_rd(8'h20);
    rim_rd(8'h12);

    // SCL-qualified instance: write 0x96 to addr 3 with glitchy SDA
    rim_xfer(1'b1, 1'b1, 8'h03, 16'h0011, rd, lat);
    chk("q_pre_lat", lat, 1);
    tw1_bit(1'b1);
    tw1_bit(1'b1);
    chk("q_idle_noglitch", if1.tw_busy, 0);
    fbits = {8'h96, 4'h3, TW_OP_WR, 1'b0};
    for (int i = 0; i < 14; i++) begin
      tw1_bit(fbits[i]);
      if (i < 13) chk($sformatf("q_busy%0d", i), if1.tw_busy, 1);
    end
    tw1_bit(1'b1);
    tw1_bit(1'b1);
    sda1_en = 1'b0;
    scl1 = 1'b0;
    @(negedge clk);
    chk("q_busy_end", if1.tw_busy, 0);
    rim_xfer(1'b1, 1'b0, 8'h03, 16'h0000, rd, lat);
    chk("q_rd_lat", lat, 1);
    chk("q_rd_data", rd, 16'h0096);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tpa_param.md
TPA_PARAM -- requirements
Module: tpa_param

Interface
REQ-001 SHALL have parameter AW, default 8, register address width; depth is 2**AW.
REQ-002 SHALL have parameter DW, default 16, register data width.
REQ-003 SHALL have parameter SCL_QUAL, default 0: 0 means SDA is sampled every clk; 1 means SDA is sampled only on clk cycles where a synchronised SCL rising edge is detected.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port SCL, input, 1, two-wire clock; used only when SCL_QUAL=1.
REQ-007 SHALL have port SDA, inout, 1, two-wire data; driven only in read-response states, otherwise hi-Z.
REQ-008 SHALL have ports cfg_req (input, 1, request), cfg_cmd (input, 1, 1=write/0=read), cfg_addr (input, AW), cfg_wdata (input, DW): register-interface master side.
REQ-009 SHALL have ports cfg_rdy (output, 1, completion pulse) and cfg_rdata (output, DW, read data).
REQ-010 SHALL have port tw_busy, output, 1, high while a two-wire frame is in progress.

Function
REQ-011 SHALL use states IDLE, RIM_WR, RIM_RD, RIM_DONE, TW_OP, TW_ADDR, TW_WDATA, TW_TURN, TW_RSTART, TW_RDATA, TW_RSTOP.
REQ-012 SHALL treat a "bit slot" as one clk when SCL_QUAL=0, or one qualified SCL rising edge when SCL_QUAL=1; SCL SHALL pass through a 2-flop synchroniser.
REQ-013 SHALL move IDLE->TW_OP when SDA is sampled 0 in a bit slot; this start takes priority over a simultaneous cfg_req.
REQ-014 SHALL take the TW_OP bit as the operation: 1=write, 0=read.
REQ-015 SHALL shift AW address bits LSB-first in TW_ADDR.
REQ-016 SHALL shift DW data bits LSB-first in TW_WDATA for a write, and commit the whole word to the register in the cycle after the last bit, then return to IDLE.
REQ-017 SHALL, for a read, hold SDA released for 1 slot (TW_TURN), drive 0 for 1 slot (TW_RSTART), drive DW data bits LSB-first (TW_RDATA), drive 1 for 1 slot (TW_RSTOP), then release SDA and return to IDLE.
REQ-018 SHALL capture read data at the end of TW_ADDR, so a concurrent write has no effect on the word in flight.
REQ-019 SHALL use one shared bit counter, width clog2(max(AW,DW)), cleared on every state entry and wrapping at each field's length minus 1.
REQ-020 SHALL hold tw_busy high in all TW_* states.
REQ-021 SHALL accept cfg_req only in IDLE when no start is present; a request arriving during a frame stalls until the frame ends.
REQ-022 SHALL, for an RIM write, write cfg_wdata to cfg_addr in RIM_WR and pulse cfg_rdy for one cycle (latency 1 clk after acceptance).
REQ-023 SHALL, for an RIM read, load cfg_rdata with the array word in RIM_RD and pulse cfg_rdy in the same cycle; cfg_rdata SHALL hold until the next RIM read.
REQ-024 SHALL pass through RIM_DONE for 1 cycle, ignoring cfg_req, before re-arbitrating in IDLE.
REQ-025 SHALL require the master to keep cfg_req, cfg_cmd, cfg_addr and cfg_wdata stable until cfg_rdy; cfg_req low in RIM_DONE ends the handshake.
REQ-026 SHALL ignore SDA during RIM_WR, RIM_RD and RIM_DONE.

Reset
REQ-027 SHALL, on reset assertion, immediately force state IDLE, cfg_rdy=0, cfg_rdata=0, SDA released, tw_busy=0, counter=0, and clear the shift registers and synchroniser.
REQ-028 SHALL not reset the register array contents.
REQ-029 SHALL abort a frame when reset is asserted mid-frame, with no partial write committed.

Structure
REQ-030 SHALL define the state enum, op constants TW_OP_WR=1 and TW_OP_RD=0, and the widths of the fixed frame fields in package tpa_pkg.
REQ-031 SHALL implement storage as sub-module tpa_regfile (parameters AW and DW; one synchronous write port; one asynchronous read port).

Verification
REQ-032 SHALL verify an RIM write then read: write addr 0x12, data 0xBEEF, then read addr 0x12 -> cfg_rdy pulses 1 cycle each; cfg_rdata=0xBEEF.
REQ-033 SHALL verify a TW write then RIM read: SDA frame 0,1, addr 0x34 LSB-first, data 0xA5C3 LSB-first -> RIM read of 0x34 returns 0xA5C3.
REQ-034 SHALL verify a TW read: preload 0x5A5A at addr 0x07 by RIM, send frame 0,0, addr 0x07 -> SDA reads Z,0, then 0x5A5A LSB-first, then 1, then Z; tw_busy high throughout.
REQ-035 SHALL verify a collision: cfg_req write to 0x01 in the same cycle SDA=0 -> TW frame completes first; cfg_rdy is asserted only after tw_busy falls.
REQ-036 SHALL verify reset mid-TW-write: reset after 5 data bits to 0x20 (prior value 0x1111) -> SDA hi-Z immediately; 0x20 still reads 0x1111.
REQ-037 SHALL verify SCL_QUAL=1 with AW=4 and DW=8: SDA toggled on every clk but stable around SCL rising edges, frame write 0x3 <- 0x96 -> RIM read returns 0x96.
